store_write_unit: RTL and testbench
===================================

// Module: store_write_unit
// PURPOSE
//  Store-side counterpart of the load-extension path: takes sb/sh/sw from MEM stage,
//  byte-aligns rs2 data, builds byte strobes, queues stores in a small FIFO and drains
//  them to data memory over a req/ack handshake. Flags misaligned/illegal stores and
//  raises a load hazard (stall) when a load hits a pending store word.
// PARAMETERS
//  DEPTH  4  store buffer entries (power of 2, >=2)
//  AW     32 address width
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  st_valid    in   1    store request from MEM stage
//  st_ready    out  1    buffer can accept (= !full)
//  st_funct3   in   3    000 sb, 001 sh, 010 sw; others illegal
//  st_addr     in   AW   byte address
//  st_data     in   32   rs2 value
//  store_fault out  1    1-cycle pulse: last request misaligned/illegal
//  mem_req     out  1    head entry valid toward data memory
//  mem_addr    out  AW   word address of head ({addr[AW-1:2],2'b00})
//  mem_wdata   out  32   aligned write data of head
//  mem_wstrb   out  4    byte enables of head
//  mem_ack     in   1    memory accepted head this cycle
//  ld_check    in   1    load in MEM stage
//  ld_addr     in   AW   load byte address
//  ld_hazard   out  1    comb.: ld_check && any valid entry with same word address
//  sb_empty    out  1    buffer empty
//  sb_count    out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Reset: all entries invalid, pointers 0; sb_count=0, sb_empty=1, mem_req=0,
//    store_fault=0, st_ready=1, mem_addr/wdata/wstrb=0. Reset mid-drain discards queue.
//  - Format: sb -> wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0];
//    sh -> wdata={2{d[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011;
//    sw -> wdata=d, wstrb=4'b1111.
//  - Legal iff funct3 in {000,001,010} and (sh: addr[0]==0), (sw: addr[1:0]==0).
//  - Enqueue when st_valid && st_ready && legal. Illegal accepted-cycle request
//    (st_valid && st_ready && !legal) is dropped; store_fault=1 next cycle only.
//  - st_ready depends only on registered full flag (no comb. path from mem_ack);
//    full FIFO takes nothing even if mem_ack pops same cycle.
//  - Latency: store enqueued in cycle N into empty buffer -> mem_req=1 in N+1.
//  - mem_req = !sb_empty; mem_addr/wdata/wstrb = head, stable until mem_ack.
//    mem_ack while mem_req=0 ignored. Pop on mem_req && mem_ack.
//  - Simultaneous enqueue+pop (not full): count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; full/empty from count, never ambiguous.
//  - Order strictly FIFO; no merging; no forwarding (hazard stalls load instead).
//  - ld_hazard compares ld_addr[AW-1:2] against every valid entry incl. head being
//    acked this cycle (conservative); entry enqueued this cycle not yet visible.
// STRUCTURE
//  - Shared include store_defs.vh: `ST_SB 3'b000, `ST_SH 3'b001, `ST_SW 3'b010,
//    strobe constants; same funct3 encoding as load path defines.
//  - Sub-module store_fifo (DEPTH x {addr,wdata,wstrb}, count, full/empty, plus
//    per-entry valid/addr taps for hazard compare). Top: format/align + fault + hazard.
// TESTING
//  - sw addr 0x100 data 0xDEADBEEF, mem_ack held -> next cycle mem_req=1,
//    mem_addr=0x100, wdata=0xDEADBEEF, wstrb=1111; popped, sb_empty=1.
//  - sb addr 0x203 data 0x000000A5 -> wdata=0xA5A5A5A5, wstrb=1000, addr=0x200;
//    sh addr 0x202 data 0x1234 -> wdata=0x12341234, wstrb=1100.
//  - sh addr 0x101; sw addr 0x102; funct3=011 -> none enqueued, store_fault pulse
//    each following cycle, sb_count stays 0.
//  - mem_ack=0, 5 stores -> 4 accepted, st_ready=0, sb_count=4; ack once -> 1st
//    store out, st_ready=1 next cycle; order of all 5 preserved.
//  - Pending sw 0x300, ld_check ld_addr 0x302 -> ld_hazard=1; ld_addr 0x304 -> 0.
//  - 3 queued, assert rst mid-cycle -> mem_req=0 immediately, sb_count=0 after.

Source files
------------

// File: rtl/store_write_unit_pkg.sv
// Shared store encodings, strobe constants and the store formatting helper.
// funct3 encoding matches the load-extension path.
package store_write_unit_pkg;

   localparam logic [2:0] ST_SB = 3'b000;
   localparam logic [2:0] ST_SH = 3'b001;
   localparam logic [2:0] ST_SW = 3'b010;

   localparam logic [3:0] STRB_BYTE0 = 4'b0001;
   localparam logic [3:0] STRB_HALF_LO = 4'b0011;
   localparam logic [3:0] STRB_HALF_HI = 4'b1100;
   localparam logic [3:0] STRB_WORD = 4'b1111;

   typedef struct packed {
      logic        legal;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } st_fmt_t;

   // Replicates the rs2 data across its lanes so only the strobe selects the bytes.
   function automatic st_fmt_t format_store(input logic [2:0] funct3,
                                            input logic [1:0] lo,
                                            input logic [31:0] d);
      st_fmt_t f;
      f = '0;
      case (funct3)
         ST_SB: begin
            f.legal = 1'b1;
            f.wdata = {4{d[7:0]}};
            f.wstrb = STRB_BYTE0 << lo;
         end
         ST_SH: begin
            f.legal = !lo[0];
            f.wdata = {2{d[15:0]}};
            f.wstrb = lo[1] ? STRB_HALF_HI : STRB_HALF_LO;
         end
         ST_SW: begin
            f.legal = (lo == 2'b00);
            f.wdata = d;
            f.wstrb = STRB_WORD;
         end
         default: f.legal = 1'b0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/store_write_unit_if.sv
// Bundle of the MEM-stage store port, data-memory write port and load hazard port.
interface store_write_unit_if #(
   parameter int AW    = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          st_valid;
   logic          st_ready;
   logic [2:0]    st_funct3;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;
   logic          store_fault;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_ack;
   logic          ld_check;
   logic [AW-1:0] ld_addr;
   logic          ld_hazard;
   logic          sb_empty;
   logic [CW-1:0] sb_count;

   modport slave (
      input  st_valid, st_funct3, st_addr, st_data, mem_ack, ld_check, ld_addr,
      output st_ready, store_fault, mem_req, mem_addr, mem_wdata, mem_wstrb,
             ld_hazard, sb_empty, sb_count
   );

   modport master (
      output st_valid, st_funct3, st_addr, st_data, mem_ack, ld_check, ld_addr,
      input  st_ready, store_fault, mem_req, mem_addr, mem_wdata, mem_wstrb,
             ld_hazard, sb_empty, sb_count
   );

endinterface

// File: rtl/store_fifo.sv
// Store buffer FIFO: word address, data and strobes per entry, with per-entry
// valid/address taps so the top can detect loads hitting a pending store.
module store_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [AW-3:0]              push_addr,
   input  logic [31:0]                push_wdata,
   input  logic [3:0]                 push_wstrb,
   input  logic                       pop,
   output logic [AW-3:0]              head_addr,
   output logic [31:0]                head_wdata,
   output logic [3:0]                 head_wstrb,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic [DEPTH-1:0]           ent_valid,
   output logic [AW-3:0]              ent_addr [DEPTH]
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]  wr_ptr_reg;
   logic [PW-1:0]  rd_ptr_reg;
   logic [CW-1:0]  count_reg;
   logic [DEPTH-1:0] valid_reg;
   logic [AW-3:0]  addr_mem  [DEPTH];
   logic [31:0]    wdata_mem [DEPTH];
   logic [3:0]     wstrb_mem [DEPTH];
   logic           do_push;
   logic           do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         valid_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i]  <= '0;
            wdata_mem[i] <= '0;
            wstrb_mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            addr_mem[wr_ptr_reg]  <= push_addr;
            wdata_mem[wr_ptr_reg] <= push_wdata;
            wstrb_mem[wr_ptr_reg] <= push_wstrb;
            valid_reg[wr_ptr_reg] <= 1'b1;
            wr_ptr_reg            <= wr_ptr_reg + PW'(1);
         end
         if (do_pop) begin
            valid_reg[rd_ptr_reg] <= 1'b0;
            rd_ptr_reg            <= rd_ptr_reg + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_addr  = addr_mem[rd_ptr_reg];
   assign head_wdata = wdata_mem[rd_ptr_reg];
   assign head_wstrb = wstrb_mem[rd_ptr_reg];
   assign count      = count_reg;
   assign ent_valid  = valid_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
         assign ent_addr[gi] = addr_mem[gi];
      end
   endgenerate

endmodule

// File: rtl/store_write_unit.sv
// Formats sb/sh/sw stores, rejects misaligned/illegal ones, buffers them and
// drains to data memory; stalls loads that hit a pending store word.
module store_write_unit
   import store_write_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input logic              clk,
   input logic              rst,
   store_write_unit_if.slave bus
);
   st_fmt_t                   fmt;
   logic                      accept;
   logic                      push;
   logic                      pop;
   logic                      fault_reg;
   logic [AW-3:0]             head_addr;
   logic [31:0]               head_wdata;
   logic [3:0]                head_wstrb;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic                      full;
   logic                      empty;
   logic [DEPTH-1:0]          ent_valid;
   logic [AW-3:0]             ent_addr [DEPTH];
   logic [DEPTH-1:0]          hit;

   assign fmt    = format_store(bus.st_funct3, bus.st_addr[1:0], bus.st_data);
   assign accept = bus.st_valid && bus.st_ready;
   assign push   = accept && fmt.legal;
   assign pop    = bus.mem_req && bus.mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fault_reg <= 1'b0;
      else     fault_reg <= accept && !fmt.legal;
   end

   store_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (bus.st_addr[AW-1:2]),
      .push_wdata (fmt.wdata),
      .push_wstrb (fmt.wstrb),
      .pop        (pop),
      .head_addr  (head_addr),
      .head_wdata (head_wdata),
      .head_wstrb (head_wstrb),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .ent_valid  (ent_valid),
      .ent_addr   (ent_addr)
   );

   // Ready comes only from the registered count, never from mem_ack.
   assign bus.st_ready    = !full;
   assign bus.store_fault = fault_reg;
   assign bus.mem_req     = !empty;
   assign bus.mem_addr    = empty ? '0 : {head_addr, 2'b00};
   assign bus.mem_wdata   = empty ? '0 : head_wdata;
   assign bus.mem_wstrb   = empty ? '0 : head_wstrb;
   assign bus.sb_empty    = empty;
   assign bus.sb_count    = count;

   // Includes the head even when it is being acked this cycle.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
         assign hit[gi] = ent_valid[gi] && (ent_addr[gi] == bus.ld_addr[AW-1:2]);
      end
   endgenerate

   assign bus.ld_hazard = bus.ld_check && (|hit);

endmodule

// File: tb/tb_store_write_unit.sv
// Directed bench for store_write_unit: expected memory writes are queued when a
// store is driven and compared when the DUT presents an acked request.
module tb_store_write_unit;
   import store_write_unit_pkg::*;

   localparam int AW    = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   store_write_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

   store_write_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.addr = {a[31:2], 2'b00};
      case (f)
         3'b000: begin e.wdata = {4{d[7:0]}};  e.wstrb = 4'b0001 << a[1:0]; end
         3'b001: begin e.wdata = {2{d[15:0]}}; e.wstrb = a[1] ? 4'b1100 : 4'b0011; end
         default: begin e.wdata = d;           e.wstrb = 4'b1111; end
      endcase
      return e;
   endfunction

   task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic expect_accept);
      bus.st_valid  = v;
      bus.st_funct3 = f;
      bus.st_addr   = a;
      bus.st_data   = d;
      if (expect_accept) sb_q.push_back(model(f, a, d));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted memory write must match the oldest expected store.
   always @(negedge clk) begin
      exp_t got;
      exp_t want;
      if (!rst && bus.mem_req && bus.mem_ack) begin
         got  = {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
         want = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
         chk("mem_write", got, want);
         $display("write addr=%h wdata=%h wstrb=%b", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end
   end

   initial begin
      bus.st_valid  = 1'b0;
      bus.st_funct3 = 3'b000;
      bus.st_addr   = '0;
      bus.st_data   = '0;
      bus.mem_ack   = 1'b0;
      bus.ld_check  = 1'b0;
      bus.ld_addr   = '0;
      #2;
      chk("rst_count", bus.sb_count, 0);
      chk("rst_empty", bus.sb_empty, 1);
      chk("rst_req", bus.mem_req, 0);
      chk("rst_ready", bus.st_ready, 1);
      chk("rst_fault", bus.store_fault, 0);
      chk("rst_bus", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // sw with ack held: visible next cycle, then drained
      bus.mem_ack = 1'b1;
      drive(1, ST_SW, 32'h100, 32'hDEADBEEF, 1);
      tick();
      drive(0, ST_SW, 32'h0, 32'h0, 0);
      chk("sw_req_latency", bus.mem_req, 1);
      chk("sw_head", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {32'h100, 32'hDEADBEEF, 4'b1111});
      tick();
      chk("sw_empty_after", bus.sb_empty, 1);

      // sb and sh alignment
      drive(1, ST_SB, 32'h203, 32'h000000A5, 1);
      tick();
      chk("sb_head", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {32'h200, 32'hA5A5A5A5, 4'b1000});
      drive(1, ST_SH, 32'h202, 32'h00001234, 1);
      tick();
      chk("sh_head", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {32'h200, 32'h12341234, 4'b1100});
      drive(0, ST_SW, 32'h0, 32'h0, 0);
      tick();
      chk("sbsh_empty", bus.sb_empty, 1);

      // illegal / misaligned stores
      drive(1, ST_SH, 32'h101, 32'h1, 0);
      tick();
      chk("fault_sh_mis", bus.store_fault, 1);
      drive(1, ST_SW, 32'h102, 32'h2, 0);
      tick();
      chk("fault_sw_mis", bus.store_fault, 1);
      drive(1, 3'b011, 32'h100, 32'h3, 0);
      tick();
      chk("fault_funct3", bus.store_fault, 1);
      chk("fault_count", bus.sb_count, 0);
      drive(0, ST_SW, 32'h0, 32'h0, 0);
      tick();
      chk("fault_clears", bus.store_fault, 0);
      chk("fault_count_end", bus.sb_count, 0);
      chk("fault_no_req", bus.mem_req, 0);

      // fill to full with no ack, 5th store must wait
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, ST_SW, 32'h400 + 32'(4 * i), 32'h11110000 + 32'(i), 1);
         tick();
      end
      drive(1, ST_SW, 32'h410, 32'h11110004, 0);
      chk("full_ready", bus.st_ready, 0);
      chk("full_count", bus.sb_count, 4);
      tick();
      chk("full_hold_count", bus.sb_count, 4);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("after_pop_ready", bus.st_ready, 1);
      chk("after_pop_count", bus.sb_count, 3);
      sb_q.push_back(model(ST_SW, 32'h410, 32'h11110004));
      tick();
      drive(0, ST_SW, 32'h0, 32'h0, 0);
      chk("refill_count", bus.sb_count, 4);
      bus.mem_ack = 1'b1;
      for (int n = 0; n < 20 && !bus.sb_empty; n++) tick();
      chk("fill_drained", bus.sb_empty, 1);

      // load hazard against a pending word
      bus.mem_ack = 1'b0;
      drive(1, ST_SW, 32'h300, 32'h0000CAFE, 1);
      tick();
      drive(0, ST_SW, 32'h0, 32'h0, 0);
      bus.ld_check = 1'b1;
      bus.ld_addr  = 32'h302;
      #1 chk("hazard_same_word", bus.ld_hazard, 1);
      bus.ld_addr = 32'h304;
      #1 chk("hazard_next_word", bus.ld_hazard, 0);
      bus.ld_check = 1'b0;
      bus.ld_addr  = 32'h300;
      #1 chk("hazard_no_check", bus.ld_hazard, 0);
      bus.mem_ack = 1'b1;
      tick();
      tick();
      chk("hazard_drained", bus.sb_empty, 1);

      // reset mid-drain discards the queue
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, ST_SB, 32'h500 + 32'(i), 32'h000000C0 + 32'(i), 1);
         tick();
      end
      drive(0, ST_SW, 32'h0, 32'h0, 0);
      chk("pre_rst_count", bus.sb_count, 3);
      chk("pre_rst_req", bus.mem_req, 1);
      @(negedge clk);
      #1 rst = 1'b1;
      sb_q.delete();
      #1 chk("rst_req_immediate", bus.mem_req, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk("post_rst_count", bus.sb_count, 0);
      chk("post_rst_empty", bus.sb_empty, 1);

      chk("queue_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
